rx_frame_filter: RTL and testbench

//   Store-and-forward filter on the MAC receive AXIS path. Sits directly downstream of the MAC rx_axis_* output and feeds the user/checker side.

---
 rtl/rx_frame_filter.sv | 159 +++++++++++++++
 tb/tb_rx_frame_filter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_filter.sv
// Store-and-forward receive filter: buffers each MAC frame and forwards it only once it
// has ended with good FCS, legal byte enables and a legal length; everything else is dropped whole.
module rx_frame_filter #(
    parameter int AW             = 9,
    parameter int MIN_BYTE_COUNT = 60,
    parameter int MAX_BYTE_COUNT = 1514
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad,
    output logic [31:0] stat_ovf
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    logic [72:0]   r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_wr_commit;
    logic [AW-1:0] r_rd_ptr;
    state_t        r_state;
    logic [CW-1:0] r_byte_cnt;
    logic          r_err;

    logic [CW-1:0] w_cnt_next;
    logic          w_err_next;
    logic          w_good;
    logic          w_full;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_ptr_inc;
    logic [72:0]   w_rd_word;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    // A last beat must enable a non-empty run of bytes starting at byte 0.
    function automatic logic keep_is_legal_last(input logic [7:0] k);
        return (k != 8'h00) && ((k & (k + 8'h01)) == 8'h00);
    endfunction

    assign w_wr_ptr_inc = r_wr_ptr + AW'(1);
    assign w_full       = (w_wr_ptr_inc == r_rd_ptr);
    assign w_wr_en      = s_axis_tvalid && (r_state != S_DROP) && !w_full;
    assign w_rd_word    = r_mem[r_rd_ptr];

    // Frame verdict including the beat currently on the input; the error flag is sticky,
    // so a byte count that later wraps cannot hide an oversize frame.
    always_comb begin
        w_cnt_next = r_byte_cnt + CW'(popcount8(s_axis_tkeep));
        w_err_next = r_err
                   | (!s_axis_tlast && (s_axis_tkeep != 8'hFF))
                   | (s_axis_tlast && !keep_is_legal_last(s_axis_tkeep))
                   | (w_cnt_next > CW'(MAX_BYTE_COUNT));
        w_good     = s_axis_tuser && !w_err_next && (w_cnt_next >= CW'(MIN_BYTE_COUNT));
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Input FSM: the MAC cannot be stalled, so a full buffer rewinds and drops the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_byte_cnt  <= '0;
            r_err       <= 1'b0;
            stat_good   <= 32'd0;
            stat_bad    <= 32'd0;
            stat_ovf    <= 32'd0;
        end else if (s_axis_tvalid) begin
            case (r_state)
                S_IDLE, S_FRAME: begin
                    if (w_full) begin
                        r_wr_ptr   <= r_wr_commit;
                        stat_ovf   <= stat_ovf + 32'd1;
                        r_byte_cnt <= '0;
                        r_err      <= 1'b0;
                        r_state    <= s_axis_tlast ? S_IDLE : S_DROP;
                    end else if (s_axis_tlast) begin
                        if (w_good) begin
                            r_wr_ptr    <= w_wr_ptr_inc;
                            r_wr_commit <= w_wr_ptr_inc;
                            stat_good   <= stat_good + 32'd1;
                        end else begin
                            r_wr_ptr <= r_wr_commit;
                            stat_bad <= stat_bad + 32'd1;
                        end
                        r_byte_cnt <= '0;
                        r_err      <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wr_ptr   <= w_wr_ptr_inc;
                        r_byte_cnt <= w_cnt_next;
                        r_err      <= w_err_next;
                        r_state    <= S_FRAME;
                    end
                end
                S_DROP: begin
                    r_byte_cnt <= '0;
                    r_err      <= 1'b0;
                    r_state    <= s_axis_tlast ? S_IDLE : S_DROP;
                end
                default: begin
                    r_byte_cnt <= '0;
                    r_err      <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Output prefetch register: only committed words (below r_wr_commit) are ever read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 64'd0;
            m_axis_tkeep  <= 8'd0;
            m_axis_tlast  <= 1'b0;
        end else if (!m_axis_tvalid || m_axis_tready) begin
            if (r_rd_ptr != r_wr_commit) begin
                m_axis_tlast  <= w_rd_word[72];
                m_axis_tkeep  <= w_rd_word[71:64];
                m_axis_tdata  <= w_rd_word[63:0];
                m_axis_tvalid <= 1'b1;
                r_rd_ptr      <= r_rd_ptr + AW'(1);
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_filter.sv
// Bench for rx_frame_filter: directed frames checked every cycle against a queue-based
// frame model, plus literal expectations on stats, latency and beat counts.
module tb_rx_frame_filter;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MINB  = 60;
    localparam int MAXB  = 1514;

    logic        clk;
    logic        reset = 1'b1;
    logic [63:0] s_axis_tdata = 64'd0;
    logic [7:0]  s_axis_tkeep = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] stat_good, stat_bad, stat_ovf;

    rx_frame_filter #(.AW(AW), .MIN_BYTE_COUNT(MINB), .MAX_BYTE_COUNT(MAXB)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .stat_good(stat_good), .stat_bad(stat_bad), .stat_ovf(stat_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int hs_last = 0;
    bit toggle_rdy = 1'b0;

    // Frame model: committed words waiting to be read, words of the frame being received.
    logic [72:0] cq[$];
    logic [72:0] pq[$];
    bit          mv = 1'b0;
    logic [72:0] mword = 73'd0;
    logic [31:0] m_good = 32'd0, m_bad = 32'd0, m_ovf = 32'd0;
    bit          m_drop = 1'b0;
    int          fbytes = 0;
    bit          ferr = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit last_keep_ok(input logic [7:0] k);
        for (int n = 1; n <= 8; n++) begin
            if (k == 8'((1 << n) - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        cq.delete(); pq.delete();
        mv = 1'b0; m_good = 32'd0; m_bad = 32'd0; m_ovf = 32'd0;
        m_drop = 1'b0; fbytes = 0; ferr = 1'b0;
    endtask

    task automatic model_step();
        int occ;
        occ = cq.size() + pq.size();
        if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt++;
            if (m_axis_tlast) hs_last++;
        end
        if (!mv || m_axis_tready) begin
            if (cq.size() != 0) begin
                mword = cq.pop_front();
                mv = 1'b1;
            end else begin
                mv = 1'b0;
            end
        end
        if (s_axis_tvalid) begin
            if (m_drop) begin
                if (s_axis_tlast) m_drop = 1'b0;
            end else if (occ == DEPTH - 1) begin
                pq.delete(); fbytes = 0; ferr = 1'b0;
                m_ovf = m_ovf + 32'd1;
                m_drop = !s_axis_tlast;
            end else begin
                pq.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
                fbytes += $countones(s_axis_tkeep);
                if (!s_axis_tlast && s_axis_tkeep != 8'hFF) ferr = 1'b1;
                if (s_axis_tlast && !last_keep_ok(s_axis_tkeep)) ferr = 1'b1;
                if (s_axis_tlast) begin
                    if (s_axis_tuser && !ferr && fbytes >= MINB && fbytes <= MAXB) begin
                        while (pq.size() != 0) cq.push_back(pq.pop_front());
                        m_good = m_good + 32'd1;
                    end else begin
                        m_bad = m_bad + 32'd1;
                    end
                    pq.delete(); fbytes = 0; ferr = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("tvalid", 80'(m_axis_tvalid), 80'(mv));
            if (mv) chk("out_word", 80'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 80'(mword));
            chk("stat_good", 80'(stat_good), 80'(m_good));
            chk("stat_bad", 80'(stat_bad), 80'(m_bad));
            chk("stat_ovf", 80'(stat_ovf), 80'(m_ovf));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (toggle_rdy) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input int nbytes, input bit user, input int bad_beat,
                              input logic [7:0] bad_keep, input logic [7:0] tag, input bit gap);
        int nb;
        int rem;
        logic [7:0] keep;
        nb = (nbytes + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            tick();
            rem  = nbytes - 8 * b;
            keep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            if (b == bad_beat) keep = bad_keep;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {tag, 8'(b), 48'h0123_4567_89AB};
            s_axis_tkeep  = keep;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tuser  = (b == nb - 1) ? user : 1'b0;
        end
        if (gap) begin
            tick();
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
    endtask

    initial begin
        idle(3);
        chk("rst_tvalid", 80'(m_axis_tvalid), 80'd0);
        chk("rst_tdata", 80'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 80'd0);
        chk("rst_stats", 80'({stat_good, stat_bad, stat_ovf}), 80'd0);
        reset = 1'b0;
        idle(2);

        // 1: 64B good frame, latency and beat count
        hs_cnt = 0; hs_last = 0;
        send_frame(64, 1'b1, -1, 8'h00, 8'h11, 1'b1);
        chk("lat_commit_edge", 80'(m_axis_tvalid), 80'd0);
        tick();
        chk("lat_read_edge", 80'(m_axis_tvalid), 80'd1);
        chk("first_word", 80'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
            80'({1'b0, 8'hFF, 8'h11, 8'h00, 48'h0123_4567_89AB}));
        idle(12);
        chk("t1_beats", 80'(hs_cnt), 80'd8);
        chk("t1_lasts", 80'(hs_last), 80'd1);
        chk("t1_good", 80'(stat_good), 80'd1);

        // 2: bad FCS dropped, next good frame intact
        hs_cnt = 0;
        send_frame(60, 1'b0, -1, 8'h00, 8'h22, 1'b1);
        send_frame(64, 1'b1, -1, 8'h00, 8'h23, 1'b1);
        idle(12);
        chk("t2_beats", 80'(hs_cnt), 80'd8);
        chk("t2_stats", 80'({stat_good, stat_bad}), 80'({32'd2, 32'd1}));

        // 3: 59B runt dropped, 60B accepted
        hs_cnt = 0;
        send_frame(59, 1'b1, -1, 8'h00, 8'h31, 1'b1);
        send_frame(60, 1'b1, -1, 8'h00, 8'h32, 1'b1);
        idle(12);
        chk("t3_beats", 80'(hs_cnt), 80'd8);
        chk("t3_stats", 80'({stat_good, stat_bad}), 80'({32'd3, 32'd2}));

        // 4: illegal last-beat tkeep, and a partial middle beat
        hs_cnt = 0;
        send_frame(67, 1'b1, 8, 8'h0B, 8'h41, 1'b1);
        send_frame(64, 1'b1, 2, 8'h7F, 8'h42, 1'b1);
        idle(12);
        chk("t4_beats", 80'(hs_cnt), 80'd0);
        chk("t4_bad", 80'(stat_bad), 80'd4);

        // 5: overflow with output stalled; the output register holds one word,
        //    so the second frame needs a ninth beat to reach full
        m_axis_tready = 1'b0;
        hs_cnt = 0;
        send_frame(64, 1'b1, -1, 8'h00, 8'h51, 1'b0);
        send_frame(72, 1'b1, -1, 8'h00, 8'h52, 1'b1);
        idle(4);
        chk("t5_stalled", 80'(hs_cnt), 80'd0);
        chk("t5_ovf", 80'(stat_ovf), 80'd1);
        chk("t5_good", 80'(stat_good), 80'd4);
        m_axis_tready = 1'b1;
        idle(20);
        chk("t5_beats", 80'(hs_cnt), 80'd8);

        // 6: async reset in the middle of output with toggling ready
        toggle_rdy = 1'b1;
        send_frame(64, 1'b1, -1, 8'h00, 8'h61, 1'b0);
        send_frame(64, 1'b1, -1, 8'h00, 8'h62, 1'b1);
        idle(5);
        chk("t6_busy", 80'(m_axis_tvalid), 80'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_tvalid", 80'(m_axis_tvalid), 80'd0);
        chk("t6_rst_stats", 80'({stat_good, stat_bad, stat_ovf}), 80'd0);
        tick();
        tick();
        toggle_rdy = 1'b0;
        m_axis_tready = 1'b1;
        reset = 1'b0;
        hs_cnt = 0; hs_last = 0;
        send_frame(64, 1'b1, -1, 8'h00, 8'h63, 1'b1);
        idle(15);
        chk("t6_beats", 80'(hs_cnt), 80'd8);
        chk("t6_lasts", 80'(hs_last), 80'd1);
        chk("t6_good", 80'(stat_good), 80'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
